// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
// Read hits return data combinationally; misses refill a whole line over a
// handshaked word port, stores always write through to memory.
// Optional feature macro: DCACHE_STATS_EN adds hit_count / miss_count ports.
module data_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic                  req_byte,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic [31:0]           rdata,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int WOFF_BITS = $clog2(LINE_WORDS);
    localparam int IDX_BITS  = $clog2(SETS);
    localparam int TAG_BITS  = ADDR_WIDTH - 2 - WOFF_BITS - IDX_BITS;
    localparam int CNT_BITS  = (WOFF_BITS > 0) ? WOFF_BITS : 1;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [31:0]           r_data [SETS][LINE_WORDS];
    logic [TAG_BITS-1:0]   r_tag  [SETS];
    logic [SETS-1:0]       r_valid;
    logic [CNT_BITS-1:0]   r_cnt;
    logic                  r_done;

    logic [IDX_BITS-1:0]   w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic [CNT_BITS-1:0]   w_woff;
    logic [ADDR_WIDTH-1:0] w_fill_addr;
    logic                  w_hit;
    logic                  w_last;
    logic [31:0]           w_word;
    logic [3:0]            w_be;

    assign w_idx = req_addr[2+WOFF_BITS +: IDX_BITS];
    assign w_tag = req_addr[ADDR_WIDTH-1 -: TAG_BITS];

    generate
        if (WOFF_BITS > 0) begin : g_woff
            assign w_woff      = req_addr[2 +: WOFF_BITS];
            assign w_fill_addr = {req_addr[ADDR_WIDTH-1:2+WOFF_BITS], r_cnt, 2'b00};
        end else begin : g_nowoff
            assign w_woff      = '0;
            assign w_fill_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};
        end
    endgenerate

    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_last = (r_cnt == CNT_BITS'(LINE_WORDS - 1));
    assign w_word = r_data[w_idx][w_woff];
    assign w_be   = req_byte ? (4'b0001 << req_addr[1:0]) : 4'b1111;

    // Next-state decode plus core/memory outputs, all derived from state and the held request
    always_comb begin
        w_next    = r_state;
        stall     = req_valid;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata = req_byte ? {4{req_wdata[7:0]}} : req_wdata;
        rdata     = req_byte ? {24'd0, w_word[{req_addr[1:0], 3'b000} +: 8]} : w_word;
        case (r_state)
            IDLE: begin
                // r_done marks the cycle in which a finished refill/write releases the core
                stall = req_valid & ~(r_done | (w_hit & ~req_we));
                if (req_valid && !r_done) begin
                    if (req_we)
                        w_next = WRITE;
                    else if (!w_hit)
                        w_next = REFILL;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = w_fill_addr;
                if (mem_ready && w_last)
                    w_next = IDLE;
            end
            WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                mem_be  = w_be;
                if (mem_ready)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Control state: FSM, refill word counter, completion flag and valid bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_valid <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state != IDLE) && (w_next == IDLE);
            if (r_state == IDLE)
                r_cnt <= '0;
            else if (r_state == REFILL && mem_ready)
                r_cnt <= r_cnt + 1'b1;
            if (r_state == REFILL && mem_ready && w_last)
                r_valid[w_idx] <= 1'b1;
        end
    end

    // Line storage: refill words, tag on the final word, and write-hit byte merge
    always_ff @(posedge clk) begin
        if (r_state == REFILL && mem_ready) begin
            r_data[w_idx][r_cnt] <= mem_rdata;
            if (w_last)
                r_tag[w_idx] <= w_tag;
        end
        if (r_state == WRITE && mem_ready && w_hit) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_be[b])
                    r_data[w_idx][w_woff][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

`ifdef DCACHE_STATS_EN
    // Saturating access statistics; hits released by a just-finished refill are not counted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (r_state == IDLE && req_valid && !req_we && w_hit && !r_done && hit_count != '1)
                hit_count <= hit_count + 32'd1;
            if (r_state == IDLE && w_next == REFILL && miss_count != '1)
                miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: the driver queues expected core responses
// and memory transactions; a monitor pops and compares them as the DUT
// completes requests and handshakes with the memory model.
// Memory model latency is 2 cycles per word.
module tb_data_cache;

    localparam int AW  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_we;
    logic          req_byte;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [31:0]   rdata;
    logic          stall;
    logic          mem_req;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;
`endif

    data_cache #(.ADDR_WIDTH(AW), .SETS(16), .LINE_WORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_byte  (req_byte),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rdata     (rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_load;
        logic [31:0] rdata;
        int          stalls;
        string       name;
    } req_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_exp_t;

    req_exp_t rq[$];
    mem_exp_t mq[$];
    req_exp_t mon_e;
    mem_exp_t mon_m;
    int       checks = 0;
    int       errors = 0;
    int       scnt   = 0;

    // Memory model: word at byte address A initially holds 0xD000_0000 | A
    logic [31:0] mem [1024];
    int          wait_cnt;

    assign mem_ready = mem_req && (wait_cnt == LAT - 1);
    assign mem_rdata = mem[mem_addr[11:2]];

    initial begin
        for (int i = 0; i < 1024; i++)
            mem[i] = 32'hD000_0000 | (i * 4);
    end

    // Memory latency counter and byte-enabled write port
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 0;
        end else if (mem_req) begin
            if (mem_ready) begin
                wait_cnt <= 0;
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b])
                            mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares core completions and memory handshakes against the queues
    always @(negedge clk) begin
        if (rst) begin
            scnt = 0;
        end else begin
            if (req_valid) begin
                if (stall) begin
                    scnt++;
                end else begin
                    if (rq.size() == 0) begin
                        check("unexpected_completion", 32'd1, 32'd0);
                    end else begin
                        mon_e = rq.pop_front();
                        if (mon_e.is_load)
                            check({mon_e.name, "_rdata"}, rdata, mon_e.rdata);
                        check({mon_e.name, "_stall_cycles"}, scnt, mon_e.stalls);
                    end
                    scnt = 0;
                end
            end else begin
                check("idle_mem_req", {31'd0, mem_req}, 32'd0);
            end
            if (mem_req && mem_ready) begin
                if (mq.size() == 0) begin
                    check("unexpected_mem_txn", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    mon_m = mq.pop_front();
                    check("mem_addr", mem_addr, mon_m.addr);
                    check("mem_we", {31'd0, mem_we}, {31'd0, mon_m.we});
                    if (mon_m.we) begin
                        check("mem_be", {28'd0, mem_be}, {28'd0, mon_m.be});
                        check("mem_wdata", mem_wdata, mon_m.wdata);
                    end
                end
            end
        end
    end

    task automatic push_mem(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata);
        mem_exp_t m;
        m.we = we; m.addr = addr; m.be = be; m.wdata = wdata;
        mq.push_back(m);
    endtask

    task automatic push_refill(input logic [31:0] base);
        for (int w = 0; w < 4; w++)
            push_mem(1'b0, base + 32'(4 * w), 4'b0000, 32'd0);
    endtask

    task automatic access(input string nm, input logic we, input logic byt,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input int exp_stalls);
        req_exp_t e;
        int       n;
        e.is_load = !we; e.rdata = exp_rdata; e.stalls = exp_stalls; e.name = nm;
        rq.push_back(e);
        req_valid = 1'b1; req_we = we; req_byte = byt; req_addr = addr; req_wdata = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall && n < 200);
        if (stall) begin
            check({nm, "_timeout"}, 32'd1, 32'd0);
            rq.delete();
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0;
        req_addr = 32'h100; req_wdata = 32'd0;
        @(negedge clk);
        check("rst_stall_follows_valid", {31'd0, stall}, 32'd1);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        req_valid = 1'b0;
        #1;
        check("rst_stall_no_valid", {31'd0, stall}, 32'd0);
`ifdef DCACHE_STATS_EN
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        push_refill(32'h100);
        access("cold_load_100", 1'b0, 1'b0, 32'h100, 32'd0, 32'hD000_0100, 9);
`ifdef DCACHE_STATS_EN
        check("miss_count_after_cold", miss_count, 32'd1);
        check("hit_count_after_cold", hit_count, 32'd0);
`endif
        access("hit_load_108", 1'b0, 1'b0, 32'h108, 32'd0, 32'hD000_0108, 0);
`ifdef DCACHE_STATS_EN
        check("hit_count_after_hit", hit_count, 32'd1);
`endif
        push_mem(1'b1, 32'h104, 4'b0010, 32'hABAB_ABAB);
        access("byte_store_hit_105", 1'b1, 1'b1, 32'h105, 32'h0000_00AB, 32'd0, 3);
        access("byte_load_105", 1'b0, 1'b1, 32'h105, 32'd0, 32'h0000_00AB, 0);
        access("word_load_104_merged", 1'b0, 1'b0, 32'h104, 32'd0, 32'hD000_AB04, 0);

        push_mem(1'b1, 32'h900, 4'b1111, 32'h1234_5678);
        access("store_miss_900", 1'b1, 1'b0, 32'h900, 32'h1234_5678, 32'd0, 3);
        access("load_100_still_hits", 1'b0, 1'b0, 32'h100, 32'd0, 32'hD000_0100, 0);

        push_refill(32'h900);
        access("evict_load_904", 1'b0, 1'b0, 32'h904, 32'd0, 32'hD000_0904, 9);
        access("load_900_written", 1'b0, 1'b0, 32'h900, 32'd0, 32'h1234_5678, 0);
        push_refill(32'h100);
        access("reload_100_misses", 1'b0, 1'b0, 32'h100, 32'd0, 32'hD000_0100, 9);
        access("byte_load_105_wt", 1'b0, 1'b1, 32'h105, 32'd0, 32'h0000_00AB, 0);
        access("byte_load_107", 1'b0, 1'b1, 32'h107, 32'd0, 32'h0000_00D0, 0);

        push_mem(1'b1, 32'h10C, 4'b1111, 32'hCAFE_F00D);
        access("word_store_hit_10c", 1'b1, 1'b0, 32'h10C, 32'hCAFE_F00D, 32'd0, 3);
        access("load_10c_updated", 1'b0, 1'b0, 32'h10C, 32'd0, 32'hCAFE_F00D, 0);

        // Reset during the second refill word of a miss to 0x300
        push_mem(1'b0, 32'h300, 4'b0000, 32'd0);
        req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 32'h300;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_req && mem_addr == 32'h304) && n < 50);
        check("reach_second_refill_word", mem_addr, 32'h304);
        #2;
        rst = 1'b1;
        req_valid = 1'b0;
        #1;
        check("rst_mid_refill_mem_req", {31'd0, mem_req}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef DCACHE_STATS_EN
        check("miss_count_cleared", miss_count, 32'd0);
`endif
        push_refill(32'h100);
        access("post_rst_load_100", 1'b0, 1'b0, 32'h100, 32'd0, 32'hD000_0100, 9);
        push_refill(32'h300);
        access("post_rst_load_300", 1'b0, 1'b0, 32'h300, 32'd0, 32'hD000_0300, 9);

        repeat (3) @(posedge clk);
        #1;
        check("req_queue_drained", rq.size(), 32'd0);
        check("mem_queue_drained", mq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
